// File: rtl/symbol_pkg.sv
// Shared types for the symbol rasterizers: coordinate defaults, FSM states, bounds record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package symbol_pkg;

  localparam int COORD_W_DEFAULT = 10;
  localparam int H_RES_DEFAULT   = 640;
  localparam int V_RES_DEFAULT   = 480;

  // Bound arithmetic width: wide enough for centre + half-size without overflow,
  // and signed so that a box hanging off the left/top edge goes negative before clipping.
  localparam int BOUND_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    EMIT,
    DONE
  } state_t;

  typedef struct packed {
    logic signed [BOUND_W-1:0] xmin;
    logic signed [BOUND_W-1:0] xmax;
    logic signed [BOUND_W-1:0] ymin;
    logic signed [BOUND_W-1:0] ymax;
  } bounds_t;

endpackage

// File: rtl/symbol_bounds.sv
// Centre/length/thickness to screen-clipped inclusive bounding box plus empty flag.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result when it needs it.
module symbol_bounds
  import symbol_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter int H_RES   = H_RES_DEFAULT,
  parameter int V_RES   = V_RES_DEFAULT
) (
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] size,
  input  logic [COORD_W-1:0] t,
  output bounds_t            bnd,
  output logic               empty
);

  localparam logic signed [BOUND_W-1:0] X_LIM = BOUND_W'(H_RES - 1);
  localparam logic signed [BOUND_W-1:0] Y_LIM = BOUND_W'(V_RES - 1);

  logic signed [BOUND_W-1:0] cx_e, cy_e, half_x, half_y;
  logic signed [BOUND_W-1:0] x_lo, x_hi, y_lo, y_hi;

  // Raw bounds from zero-extended inputs, then clip to the visible screen.
  always_comb begin
    cx_e   = $signed(BOUND_W'(cx));
    cy_e   = $signed(BOUND_W'(cy));
    half_x = $signed(BOUND_W'(t >> 1));
    half_y = $signed(BOUND_W'(size >> 1));

    x_lo = cx_e - half_x;
    x_hi = cx_e + half_x;
    y_lo = cy_e - half_y;
    y_hi = cy_e + half_y;

    bnd.xmin = x_lo[BOUND_W-1] ? '0 : x_lo;
    bnd.ymin = y_lo[BOUND_W-1] ? '0 : y_lo;
    bnd.xmax = (x_hi > X_LIM) ? X_LIM : x_hi;
    bnd.ymax = (y_hi > Y_LIM) ? Y_LIM : y_hi;

    // A centre far off-screen clips to an inverted box.
    empty = (bnd.xmin > bnd.xmax) || (bnd.ymin > bnd.ymax);
  end

endmodule

// File: rtl/symbol_rasterizer.sv
// Walks the clipped bar box in raster order and streams each covered pixel coordinate.
// Latency: first pixel two cycles after start is accepted; done one cycle after the last handshake.
// Backpressure: px_valid/px_x/px_y hold while px_ready is low; one pixel per cycle when ready stays high.
module symbol_rasterizer
  import symbol_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter int H_RES   = H_RES_DEFAULT,
  parameter int V_RES   = V_RES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] size,
  input  logic [COORD_W-1:0] t,
  output logic               busy,
  output logic               done,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y
);

  state_t             state;
  logic [COORD_W-1:0] cx_r, cy_r, size_r, t_r;
  bounds_t            bnd, bnd_r;
  logic               empty;

  symbol_bounds #(
    .COORD_W (COORD_W),
    .H_RES   (H_RES),
    .V_RES   (V_RES)
  ) u_bounds (
    .cx    (cx_r),
    .cy    (cy_r),
    .size  (size_r),
    .t     (t_r),
    .bnd   (bnd),
    .empty (empty)
  );

  // Counters compare against the registered box; clipped bounds are never negative.
  logic [BOUND_W-1:0] x_ext, y_ext;
  logic               x_last, y_last, accept;

  assign x_ext  = BOUND_W'(px_x);
  assign y_ext  = BOUND_W'(px_y);
  assign x_last = (x_ext >= $unsigned(bnd_r.xmax));
  assign y_last = (y_ext >= $unsigned(bnd_r.ymax));
  assign accept = px_valid && px_ready;

  // Clipped minima always fit in COORD_W; their upper bits are sign/guard bits only.
  logic unused_bits;
  assign unused_bits = ^{bnd.xmin[BOUND_W-1:COORD_W], bnd.ymin[BOUND_W-1:COORD_W],
                         bnd_r.xmin[BOUND_W-1:COORD_W], bnd_r.ymin[BOUND_W-1:COORD_W]};

  // Control FSM; pixel coordinate outputs double as the raster counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      px_valid <= 1'b0;
      px_x     <= '0;
      px_y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cx_r   <= cx;
            cy_r   <= cy;
            size_r <= size;
            t_r    <= t;
            busy   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          bnd_r <= bnd;
          if (empty) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            px_x     <= bnd.xmin[COORD_W-1:0];
            px_y     <= bnd.ymin[COORD_W-1:0];
            px_valid <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (accept) begin
            if (!x_last) begin
              px_x <= px_x + COORD_W'(1);
            end else if (!y_last) begin
              px_x <= bnd_r.xmin[COORD_W-1:0];
              px_y <= px_y + COORD_W'(1);
            end else begin
              px_valid <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_symbol_rasterizer.sv
// Scoreboard bench for symbol_rasterizer: reference pixel list built from the box rules,
// a negedge monitor pops and compares every handshake and checks stall stability.
module tb_symbol_rasterizer;

  localparam int CW = 10;
  localparam int HR = 640;
  localparam int VR = 480;

  logic          clk = 1'b0;
  logic          rst, start, px_ready;
  logic [CW-1:0] cx, cy, size, t;
  logic          busy, done, px_valid;
  logic [CW-1:0] px_x, px_y;

  symbol_rasterizer #(.COORD_W(CW), .H_RES(HR), .V_RES(VR)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cx       (cx),
    .cy       (cy),
    .size     (size),
    .t        (t),
    .busy     (busy),
    .done     (done),
    .px_valid (px_valid),
    .px_ready (px_ready),
    .px_x     (px_x),
    .px_y     (px_y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            exp_q[$];
  int            hs_count = 0;
  int            last_hs_cyc = -1;
  int            first_hs = -1;
  int            last_hs = -1;
  bit            ready_rand = 1'b0;
  bit            pend = 1'b0;
  logic [CW-1:0] hold_x, hold_y;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Downstream ready: constant high or a coin flip each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1 px_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: every handshake must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("stall_valid", int'(px_valid), 1);
          check("stall_x", int'(px_x), int'(hold_x));
          check("stall_y", int'(px_y), int'(hold_y));
        end
        if (px_valid && px_ready) begin
          int act;
          act = int'(px_x) * 4096 + int'(px_y);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_pixel: got (%0d,%0d), expected no pixel", px_x, px_y);
          end else begin
            check("pixel", act, exp_q.pop_front());
          end
          if (hs_count == 0) first_hs = act;
          last_hs = act;
          hs_count++;
          last_hs_cyc = cyc;
        end
        pend   = px_valid && !px_ready;
        hold_x = px_x;
        hold_y = px_y;
      end
    end
  end

  // Reference: every (x,y) inside the clipped inclusive box, y outer, x inner.
  task automatic model(input int mcx, input int mcy, input int msz, input int mt, output int n);
    int xl, xh, yl, yh;
    xl = mcx - mt / 2;
    xh = mcx + mt / 2;
    yl = mcy - msz / 2;
    yh = mcy + msz / 2;
    if (xl < 0) xl = 0;
    if (yl < 0) yl = 0;
    if (xh > HR - 1) xh = HR - 1;
    if (yh > VR - 1) yh = VR - 1;
    n = 0;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) begin
        exp_q.push_back(x * 4096 + y);
        n++;
      end
  endtask

  task automatic issue_start(input int rcx, input int rcy, input int rsz, input int rt,
                             output int start_cyc);
    @(posedge clk);
    #1;
    cx = CW'(rcx);
    cy = CW'(rcy);
    size = CW'(rsz);
    t = CW'(rt);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_req(input int rcx, input int rcy, input int rsz, input int rt,
                         input bit poke_start);
    int n, start_cyc, first_v, done_cyc;
    exp_q.delete();
    model(rcx, rcy, rsz, rt, n);
    hs_count = 0;
    last_hs_cyc = -1;
    first_hs = -1;
    last_hs = -1;
    issue_start(rcx, rcy, rsz, rt, start_cyc);
    first_v = -1;
    done_cyc = -1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (px_valid && first_v < 0) first_v = cyc;
      if (poke_start && i == 5) begin
        start = 1'b1;
        cx = CW'($urandom_range(0, 600));
        t = CW'($urandom_range(0, 20));
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cyc = cyc;
        check("busy_in_done", int'(busy), 1);
        break;
      end
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done, expected done within 20000 cycles");
    end
    check("pix_count", hs_count, n);
    check("queue_empty", exp_q.size(), 0);
    if (n > 0) begin
      check("first_valid_cyc", first_v, start_cyc + 2);
      check("done_after_last", done_cyc, last_hs_cyc + 1);
    end else begin
      check("empty_no_valid", first_v, -1);
      check("empty_done_cyc", done_cyc, start_cyc + 2);
    end
    @(negedge clk);
    check("done_pulse", int'(done), 0);
    check("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int dummy_cyc;
    rst = 1'b1;
    start = 1'b0;
    cx = '0;
    cy = '0;
    size = '0;
    t = '0;
    px_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(px_valid), 0);
    check("rst_px_x", int'(px_x), 0);
    check("rst_px_y", int'(px_y), 0);
    rst = 1'b0;

    // Nominal bar, ready always high.
    run_req(100, 50, 30, 3, 1'b0);
    check("t1_count", hs_count, 93);
    check("t1_first", first_hs, 99 * 4096 + 35);
    check("t1_last", last_hs, 101 * 4096 + 65);

    // Same bar under random backpressure.
    ready_rand = 1'b1;
    run_req(100, 50, 30, 3, 1'b0);
    check("t2_count", hs_count, 93);

    // Left/top clipping and right-edge clipping.
    ready_rand = 1'b0;
    run_req(0, 5, 20, 4, 1'b0);
    check("clip_lt_count", hs_count, 48);
    check("clip_lt_first", first_hs, 0 * 4096 + 0);
    run_req(639, 100, 6, 4, 1'b0);
    check("clip_r_first", first_hs, 637 * 4096 + 97);
    check("clip_r_last", last_hs, 639 * 4096 + 103);

    // Fully off-screen box and the single-pixel degenerate case.
    run_req(700, 10, 4, 2, 1'b0);
    check("empty_count", hs_count, 0);
    run_req(200, 300, 0, 0, 1'b0);
    check("single_pix", first_hs, 200 * 4096 + 300);

    // start pulsed while streaming is ignored.
    ready_rand = 1'b1;
    run_req(100, 50, 30, 3, 1'b1);

    // Reset in the middle of a stream, then a clean run.
    exp_q.delete();
    begin
      int n_abort;
      model(100, 50, 30, 3, n_abort);
    end
    issue_start(100, 50, 30, 3, dummy_cyc);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(px_valid), 0);
    check("abort_done", int'(done), 0);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_quiet", int'(px_valid), 0);
    end
    run_req(320, 240, 11, 5, 1'b0);

    // Randomized requests under random backpressure.
    for (int k = 0; k < 6; k++) begin
      run_req($urandom_range(0, 700), $urandom_range(0, 500),
              $urandom_range(0, 40), $urandom_range(0, 9), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
